irq_ctl: RTL and testbench

Interrupt request controller for the 8-bit-bus CPU. It turns single-cycle event strobes into the CPU's toggle-style request lines: keyboard, mouse and an internal periodic timer. Each source queues events and holds further toggles until the CPU has taken the current one. "Taken" is detected by snooping the CPU address bus for a fetch at that source's vector. The block sits between the PS/2 receivers and the CPU's IRQ_KEYB/IRQ_MOUSE/IRQ_TIMER inputs.

---
 rtl/irq_ctl.sv | 64 ++++++
 tb/tb_irq_ctl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/irq_ctl.sv
// irq_ctl: keyb/mouse/timer event strobes to toggle IRQ lines; per-source pending queue, ack by snooping ADDR for the source vector
module irq_ctl #(
  parameter int TIMER_DIV = 250000,
  parameter int QDEPTH_W  = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        KEYB_STB,
  input  logic        MOUSE_STB,
  input  logic        TIMER_EN,
  input  logic [15:0] ADDR,
  input  logic        OVF_CLR,
  output logic        IRQ_KEYB,
  output logic        IRQ_MOUSE,
  output logic        IRQ_TIMER,
  output logic [2:0]  BUSY,
  output logic [2:0]  OVERFLOW
);
  localparam logic [23:0] DIV_MAX = 24'(TIMER_DIV - 1);
  localparam logic [QDEPTH_W-1:0] CMAX = '1;
  logic [23:0] div_q, div_d;
  logic tmr_stb;
  logic [2:0] stb, ack, busy_q, busy_d, tog_q, tog_d, ovf_q, ovf_d;
  logic [QDEPTH_W-1:0] cnt_q [3];
  logic [QDEPTH_W-1:0] cnt_d [3];
  assign tmr_stb = TIMER_EN && div_q == DIV_MAX;
  assign div_d = (!TIMER_EN || tmr_stb) ? '0 : div_q + 24'd1;
  assign stb = {tmr_stb, MOUSE_STB, KEYB_STB};
  assign ack = {ADDR == 16'h0006, ADDR == 16'h0004, ADDR == 16'h0002};
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_q  <= '0;
      busy_q <= '0;
      tog_q  <= '0;
      ovf_q  <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      div_q  <= div_d;
      busy_q <= busy_d;
      tog_q  <= tog_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end
  always_comb begin
    busy_d = busy_q;
    for (int c = 0; c < 3; c++)
      busy_d[c] = busy_q[c] ? !ack[c] : (stb[c] || cnt_q[c] != '0);
  end
  always_comb begin
    tog_d = tog_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    for (int c = 0; c < 3; c++) begin
      tog_d[c] = tog_q[c] ^ (!busy_q[c] && (stb[c] || cnt_q[c] != '0));
      cnt_d[c] = !busy_q[c] ? ((stb[c] || cnt_q[c] == '0) ? cnt_q[c] : cnt_q[c] - 1'b1)
               : (stb[c] && cnt_q[c] != CMAX) ? cnt_q[c] + 1'b1 : cnt_q[c];
      ovf_d[c] = (ovf_q[c] && !OVF_CLR) || (busy_q[c] && stb[c] && cnt_q[c] == CMAX);
    end
  end
  assign {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB} = tog_q;
  assign BUSY = busy_q;
  assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: randomized and directed checks of irq_ctl against an event-queue reference model
module tb_irq_ctl;
  localparam int DIV = 5;
  localparam int QW = 4;
  localparam int QMAX = (1 << QW) - 1;
  logic CLOCK = 0, RESET = 1, KEYB_STB = 0, MOUSE_STB = 0, TIMER_EN = 0, OVF_CLR = 0;
  logic [15:0] ADDR = 16'h0100;
  logic IRQ_KEYB, IRQ_MOUSE, IRQ_TIMER;
  logic [2:0] BUSY, OVERFLOW;
  int checks = 0, errors = 0;
  bit mt[3], mb[3], mo[3];
  int mp[3];
  int tcount = 0;
  irq_ctl #(.TIMER_DIV(DIV), .QDEPTH_W(QW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .KEYB_STB(KEYB_STB), .MOUSE_STB(MOUSE_STB),
    .TIMER_EN(TIMER_EN), .ADDR(ADDR), .OVF_CLR(OVF_CLR), .IRQ_KEYB(IRQ_KEYB),
    .IRQ_MOUSE(IRQ_MOUSE), .IRQ_TIMER(IRQ_TIMER), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
  );
  always #5 CLOCK = ~CLOCK;
  function automatic logic [8:0] obs();
    return {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB, BUSY, OVERFLOW};
  endfunction
  function automatic logic [8:0] mexp();
    return {mt[2], mt[1], mt[0], mb[2], mb[1], mb[0], mo[2], mo[1], mo[0]};
  endfunction
  task automatic model(input bit k, m, en, input logic [15:0] a, input bit clr, rst);
    bit s[3];
    bit lost;
    bit ts;
    ts = en && (tcount % DIV == DIV - 1);
    tcount = (en && !rst) ? tcount + 1 : 0;
    s = '{k, m, ts};
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        mt[c] = 0; mb[c] = 0; mo[c] = 0; mp[c] = 0;
      end else begin
        lost = 0;
        if (!mb[c]) begin
          if (s[c] || mp[c] > 0) begin
            mt[c] = !mt[c];
            mb[c] = 1;
            if (!s[c]) mp[c]--;
          end
        end else begin
          if (s[c]) begin
            if (mp[c] == QMAX) lost = 1;
            else mp[c]++;
          end
          if (a == 16'(2 * (c + 1))) mb[c] = 0;
        end
        mo[c] = (mo[c] && !clr) || lost;
      end
    end
  endtask
  task automatic cyc(input bit k, m, en, input logic [15:0] a, input bit clr, rst);
    KEYB_STB = k; MOUSE_STB = m; TIMER_EN = en; ADDR = a; OVF_CLR = clr; RESET = rst;
    @(posedge CLOCK);
    model(k, m, en, a, clr, rst);
    #1;
  endtask
  task automatic test_reset();
    cyc(0, 0, 0, 16'h0100, 0, 1);
    cyc(0, 0, 0, 16'h0100, 0, 1);
    checks++;
    if (obs() !== 9'd0) begin errors++; $display("FAIL reset got %b want %b", obs(), 9'd0); end
  endtask
  task automatic test_keyb_queue();
    cyc(0, 0, 0, 16'h0100, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 16'h0100, 0, 0);
    cyc(1, 0, 0, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_KEYB, BUSY} !== 4'b1001) begin errors++; $display("FAIL keyb_issue got %b want 1001", {IRQ_KEYB, BUSY}); end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 16'h0100, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_KEYB, BUSY} !== 4'b1001) begin errors++; $display("FAIL keyb_hold got %b want 1001", {IRQ_KEYB, BUSY}); end
    cyc(0, 0, 0, 16'h0002, 0, 0);
    checks++;
    if (BUSY !== 3'b000) begin errors++; $display("FAIL keyb_ack got %b want 000", BUSY); end
    cyc(0, 0, 0, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_KEYB, BUSY} !== 4'b0001) begin errors++; $display("FAIL keyb_reissue got %b want 0001", {IRQ_KEYB, BUSY}); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 16'h0002, 0, 0);
      cyc(0, 0, 0, 16'h0100, 0, 0);
      checks++;
      if (obs() !== mexp()) begin errors++; $display("FAIL keyb_drain%0d got %b want %b", i, obs(), mexp()); end
    end
    checks++;
    if ({IRQ_KEYB, BUSY} !== 4'b0000) begin errors++; $display("FAIL keyb_empty got %b want 0000", {IRQ_KEYB, BUSY}); end
  endtask
  task automatic test_overflow();
    cyc(0, 0, 0, 16'h0100, 0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_MOUSE, OVERFLOW} !== 4'b1000) begin errors++; $display("FAIL mouse_full got %b want 1000", {IRQ_MOUSE, OVERFLOW}); end
    cyc(0, 1, 0, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_MOUSE, OVERFLOW} !== 4'b1010) begin errors++; $display("FAIL mouse_ovf got %b want 1010", {IRQ_MOUSE, OVERFLOW}); end
    cyc(0, 0, 0, 16'h0100, 1, 0);
    checks++;
    if (OVERFLOW !== 3'b000) begin errors++; $display("FAIL ovf_clr got %b want 000", OVERFLOW); end
    cyc(0, 1, 0, 16'h0100, 1, 0);
    checks++;
    if (OVERFLOW !== 3'b010) begin errors++; $display("FAIL ovf_clr_set got %b want 010", OVERFLOW); end
    checks++;
    if (obs() !== mexp()) begin errors++; $display("FAIL ovf_model got %b want %b", obs(), mexp()); end
  endtask
  task automatic test_timer();
    int flips = 0;
    logic last;
    cyc(0, 0, 0, 16'h0100, 0, 1);
    last = IRQ_TIMER;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, i < 12, mb[2] ? 16'h0006 : 16'h0100, 0, 0);
      if (IRQ_TIMER !== last) flips++;
      last = IRQ_TIMER;
      checks++;
      if (obs() !== mexp()) begin errors++; $display("FAIL timer_c%0d got %b want %b", i, obs(), mexp()); end
    end
    checks++;
    if (flips != 2) begin errors++; $display("FAIL timer_flips got %0d want 2", flips); end
  endtask
  task automatic test_back_to_back();
    cyc(0, 0, 0, 16'h0100, 0, 1);
    for (int i = 0; i < DIV - 1; i++) cyc(0, 0, 1, 16'h0100, 0, 0);
    cyc(1, 1, 1, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB, BUSY} !== 6'b111111) begin
      errors++; $display("FAIL all_three got %b want 111111", {IRQ_TIMER, IRQ_MOUSE, IRQ_KEYB, BUSY});
    end
    cyc(0, 0, 0, 16'h0004, 0, 0);
    checks++;
    if (BUSY !== 3'b101) begin errors++; $display("FAIL ack_mouse got %b want 101", BUSY); end
  endtask
  task automatic test_same_cycle();
    cyc(0, 0, 0, 16'h0100, 0, 1);
    cyc(1, 0, 0, 16'h0100, 0, 0);
    cyc(1, 0, 0, 16'h0002, 0, 0);
    checks++;
    if ({IRQ_KEYB, BUSY} !== 4'b1000) begin errors++; $display("FAIL stb_ack got %b want 1000", {IRQ_KEYB, BUSY}); end
    cyc(0, 0, 0, 16'h0100, 0, 0);
    checks++;
    if ({IRQ_KEYB, BUSY} !== 4'b0001) begin errors++; $display("FAIL stb_ack_next got %b want 0001", {IRQ_KEYB, BUSY}); end
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0100, 0, 0);
    cyc(0, 0, 0, 16'h0100, 0, 1);
    checks++;
    if (obs() !== 9'd0) begin errors++; $display("FAIL mid_reset got %b want 0", obs()); end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'h0002, 0, 0);
    checks++;
    if (obs() !== 9'd0) begin errors++; $display("FAIL post_reset got %b want 0", obs()); end
  endtask
  task automatic test_random();
    logic [15:0] a;
    bit en = 0;
    cyc(0, 0, 0, 16'h0100, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = !en;
      case ($urandom_range(0, 5))
        0: a = 16'h0002;
        1: a = 16'h0004;
        2: a = 16'h0006;
        3: a = 16'(($urandom_range(0, 3)) * 2 + 1);
        default: a = 16'($urandom);
      endcase
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, en, a,
          $urandom_range(0, 30) == 0, $urandom_range(0, 199) == 0);
      checks++;
      if (obs() !== mexp()) begin errors++; $display("FAIL rand_c%0d got %b want %b", i, obs(), mexp()); end
    end
  endtask
  initial begin
    test_reset();
    test_keyb_queue();
    test_overflow();
    test_timer();
    test_back_to_back();
    test_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
